// File: rtl/core_hazard_ctrl_pkg.sv
// core_hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller: forwarding source
//   codes, shadow-entry field widths and the width helpers used to size the
//   forwarding selects and the performance counters.
package core_hazard_ctrl_pkg;

    // Forwarding source codes; code s selects tracked stage s.
    localparam int unsigned FWD_RF = 0;
    localparam int unsigned FWD_A  = 1;
    localparam int unsigned FWD_C  = 2;
    localparam int unsigned FWD_W  = 3;

    // Shadow-entry flag field widths.
    localparam int unsigned ENT_IS_WB_W   = 1;
    localparam int unsigned ENT_IS_LOAD_W = 1;

    typedef struct packed {
        logic [ENT_IS_WB_W-1:0]   is_wb;
        logic [ENT_IS_LOAD_W-1:0] is_load;
    } ent_flags_t;

    // Width of one forwarding select: must encode 0 (regfile) .. depth.
    function automatic int unsigned fs_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // A counter width of 0 means "size to the datapath".
    function automatic int unsigned cnt_width(input int unsigned cnt_w, input int unsigned xlen);
        return (cnt_w == 0) ? xlen : cnt_w;
    endfunction

endpackage

// File: rtl/core_hazard_slot.sv
// core_hazard_slot
//   One shadow pipeline stage of the hazard controller. Holds the entry
//   {valid, rd, is_wb, is_load} of the instruction currently in that stage and
//   compares it against every D-stage source index.
// Ports
//   clock, reset        core clock, synchronous active-high reset
//   hold                keep the current entry instead of taking in_*
//   in_valid/rd/flags   entry presented by the previous stage (or by D)
//   rs, rs_used         D-stage source indices and their read-enables
//   valid, rd, flags    registered entry, forwarded to the next stage
//   match               per read port: this entry is a writer of that source
module core_hazard_slot
    import core_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned NREAD = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   hold,
    input  logic                   in_valid,
    input  logic [REG_W-1:0]       in_rd,
    input  ent_flags_t             in_flags,
    input  logic [NREAD*REG_W-1:0] rs,
    input  logic [NREAD-1:0]       rs_used,
    output logic                   valid,
    output logic [REG_W-1:0]       rd,
    output ent_flags_t             flags,
    output logic [NREAD-1:0]       match
);

    logic             valid_q, valid_d;
    logic [REG_W-1:0] rd_q, rd_d;
    ent_flags_t       flags_q, flags_d;
    logic             writer;

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        flags_d = flags_q;
        if (!hold) begin
            valid_d = in_valid;
            rd_d    = in_rd;
            flags_d = in_flags;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            flags_q <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            flags_q <= flags_d;
        end
    end

    // x0 is never a real destination, so it never produces a writer.
    assign writer = valid_q & flags_q.is_wb & (rd_q != '0);

    // A zero source index can never match because writers exclude rd = 0.
    always_comb begin
        match = '0;
        for (int unsigned k = 0; k < NREAD; k++) begin
            match[k] = writer & rs_used[k] & (rs[k*REG_W +: REG_W] == rd_q);
        end
    end

    assign valid = valid_q;
    assign rd    = rd_q;
    assign flags = flags_q;

endmodule

// File: rtl/core_hazard_ctrl.sv
// core_hazard_ctrl
//   Pipeline hazard controller for the in-order core. Shadows every in-flight
//   instruction between D and write-back, picks the D-stage forwarding source
//   per read port, and raises stall/bubble/hold/flush for memory waits,
//   load-use hazards and taken branches.
// Ports
//   clock, reset                 core clock, synchronous active-high reset
//   d_valid, d_rd, d_is_wb,
//   d_is_load                    instruction currently in D
//   d_rs, d_rs_used              D source indices (port k at [k*REG_W +: REG_W])
//   br_en                        taken branch resolved in D
//   mem_req, mem_ready           C-stage memory access and its completion
//   stall_fd                     hold PC and F-D register
//   bubble_da                    inject an invalid entry into D-A
//   hold_pipe                    freeze D-A, A-C and C-W
//   flush_fd                     invalidate F-D at the next edge
//   fwd_sel                      per port: 0 = regfile, s = tracked stage s
//   inflight                     shadow valid bits, bit s-1 = stage s
//   stall_cnt, flush_cnt         saturating performance counters
module core_hazard_ctrl
    import core_hazard_ctrl_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_W      = 5,
    parameter int unsigned NREAD      = 2,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   d_valid,
    input  logic [REG_W-1:0]                       d_rd,
    input  logic                                   d_is_wb,
    input  logic                                   d_is_load,
    input  logic [NREAD*REG_W-1:0]                 d_rs,
    input  logic [NREAD-1:0]                       d_rs_used,
    input  logic                                   br_en,
    input  logic                                   mem_req,
    input  logic                                   mem_ready,
    output logic                                   stall_fd,
    output logic                                   bubble_da,
    output logic                                   hold_pipe,
    output logic                                   flush_fd,
    output logic [NREAD*fs_width(DEPTH)-1:0]       fwd_sel,
    output logic [DEPTH-1:0]                       inflight,
    output logic [cnt_width(CNT_W, XLEN)-1:0]      stall_cnt,
    output logic [cnt_width(CNT_W, XLEN)-1:0]      flush_cnt
);

    localparam int unsigned FS_W = fs_width(DEPTH);
    localparam int unsigned CW   = cnt_width(CNT_W, XLEN);

    // Shadow chain: in_* feeds slot s, s_* is what slot s holds.
    logic [DEPTH-1:0] in_valid;
    logic [REG_W-1:0] in_rd   [DEPTH];
    ent_flags_t       in_flags[DEPTH];
    logic [DEPTH-1:0] s_valid;
    logic [REG_W-1:0] s_rd    [DEPTH];
    ent_flags_t       s_flags [DEPTH];
    logic [NREAD-1:0] s_match [DEPTH];

    logic mem_wait;
    logic load_hit;
    logic load_use;

    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        in_valid    = '0;
        in_valid[0] = d_valid & ~bubble_da;
        in_rd[0]    = d_rd;
        in_flags[0] = '{is_wb: d_is_wb, is_load: d_is_load};
        for (int unsigned s = 1; s < DEPTH; s++) begin
            in_valid[s] = s_valid[s-1];
            in_rd[s]    = s_rd[s-1];
            in_flags[s] = s_flags[s-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        core_hazard_slot #(
            .REG_W (REG_W),
            .NREAD (NREAD)
        ) u_slot (
            .clock    (clock),
            .reset    (reset),
            .hold     (hold_pipe),
            .in_valid (in_valid[g]),
            .in_rd    (in_rd[g]),
            .in_flags (in_flags[g]),
            .rs       (d_rs),
            .rs_used  (d_rs_used),
            .valid    (s_valid[g]),
            .rd       (s_rd[g]),
            .flags    (s_flags[g]),
            .match    (s_match[g])
        );
    end

    // Memory wait: the load/store stage is occupied and memory has not answered.
    assign mem_wait = s_valid[LOAD_STAGE-1] & mem_req & ~mem_ready;

    // Load-use: a used source is produced by a load whose data is not yet
    // forwardable (stage below LOAD_STAGE).
    always_comb begin
        load_hit = 1'b0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
            if ((s + 1 < LOAD_STAGE) && s_flags[s].is_load && (|s_match[s])) begin
                load_hit = 1'b1;
            end
        end
    end

    assign load_use = ~mem_wait & load_hit;

    // Control priority: memory wait > load-use > branch.
    assign hold_pipe = mem_wait;
    assign stall_fd  = mem_wait | load_use;
    assign bubble_da = load_use;
    assign flush_fd  = ~stall_fd & d_valid & br_en;

    // Youngest eligible writer wins; non-forwardable loads are skipped.
    always_comb begin
        fwd_sel = '0;
        for (int unsigned k = 0; k < NREAD; k++) begin
            logic found;
            found = 1'b0;
            fwd_sel[k*FS_W +: FS_W] = FS_W'(FWD_RF);
            for (int unsigned s = 0; s < DEPTH; s++) begin
                if (!found && s_match[s][k] && !(s_flags[s].is_load && (s + 1 < LOAD_STAGE))) begin
                    found = 1'b1;
                    fwd_sel[k*FS_W +: FS_W] = FS_W'(s + 1);
                end
            end
        end
    end

    assign inflight = s_valid;

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_fd && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CW'(1);
        end
        if (flush_fd && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// tb_core_hazard_ctrl
//   Directed bench for core_hazard_ctrl with default parameters. Expected
//   values are queued as each step is driven and popped when the outputs are
//   sampled on the falling clock edge.
module tb_core_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        d_valid;
    logic [4:0]  d_rd;
    logic        d_is_wb;
    logic        d_is_load;
    logic [9:0]  d_rs;
    logic [1:0]  d_rs_used;
    logic        br_en;
    logic        mem_req;
    logic        mem_ready;
    logic        stall_fd;
    logic        bubble_da;
    logic        hold_pipe;
    logic        flush_fd;
    logic [3:0]  fwd_sel;
    logic [2:0]  inflight;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int vectors     = 0;
    int miscompares = 0;

    string       tag_q[$];
    logic [63:0] exp_q[$];

    core_hazard_ctrl #(
        .XLEN       (32),
        .REG_W      (5),
        .NREAD      (2),
        .DEPTH      (3),
        .LOAD_STAGE (2),
        .CNT_W      (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .d_valid   (d_valid),
        .d_rd      (d_rd),
        .d_is_wb   (d_is_wb),
        .d_is_load (d_is_load),
        .d_rs      (d_rs),
        .d_rs_used (d_rs_used),
        .br_en     (br_en),
        .mem_req   (mem_req),
        .mem_ready (mem_ready),
        .stall_fd  (stall_fd),
        .bubble_da (bubble_da),
        .hold_pipe (hold_pipe),
        .flush_fd  (flush_fd),
        .fwd_sel   (fwd_sel),
        .inflight  (inflight),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic expect_val(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [63:0] obs);
        string       tag;
        logic [63:0] exp;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: got %0h, expected a queued value", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                miscompares++;
                $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
            end
        end
    endtask

    task automatic set_d(input logic v, input logic [4:0] rd, input logic wb, input logic ld,
                         input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used);
        d_valid   = v;
        d_rd      = rd;
        d_is_wb   = wb;
        d_is_load = ld;
        d_rs      = {rs1, rs0};
        d_rs_used = used;
    endtask

    task automatic idle();
        set_d(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
        br_en     = 1'b0;
        mem_req   = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // Reset state
        expect_val("rst_inflight", 0);
        expect_val("rst_stall_cnt", 0);
        expect_val("rst_flush_cnt", 0);
        expect_val("rst_ctrl", 0);
        expect_val("rst_fwd", 0);
        settle();
        check(inflight);
        check(stall_cnt);
        check(flush_cnt);
        check({stall_fd, bubble_da, hold_pipe, flush_fd});
        check(fwd_sel);
        next_cycle();

        // Back-to-back ALU ops: add x5, then readers of x5
        set_d(1, 5'd5, 1, 0, 5'd0, 5'd0, 2'b00);
        expect_val("alu0_fwd", 0);
        settle();
        check(fwd_sel);
        next_cycle();
        set_d(1, 5'd6, 1, 0, 5'd5, 5'd0, 2'b01);
        expect_val("alu1_fwd0", 1);
        expect_val("alu1_stall", 0);
        expect_val("alu1_inflight", 3'b001);
        settle();
        check(fwd_sel[1:0]);
        check(stall_fd);
        check(inflight);
        next_cycle();
        set_d(1, 5'd8, 1, 0, 5'd5, 5'd0, 2'b01);
        expect_val("alu2_fwd0", 2);
        expect_val("alu2_stall", 0);
        expect_val("alu2_inflight", 3'b011);
        settle();
        check(fwd_sel[1:0]);
        check(stall_fd);
        check(inflight);
        next_cycle();

        // Load-use: lw x7 then add with rs2 = x7
        do_reset();
        set_d(1, 5'd7, 1, 1, 5'd0, 5'd0, 2'b00);
        expect_val("lu0_stall", 0);
        settle();
        check(stall_fd);
        next_cycle();
        set_d(1, 5'd9, 1, 0, 5'd1, 5'd7, 2'b10);
        expect_val("lu1_stall_bubble_hold", 3'b110);
        settle();
        check({stall_fd, bubble_da, hold_pipe});
        next_cycle();
        expect_val("lu2_stall_bubble", 2'b00);
        expect_val("lu2_fwd1", 2);
        expect_val("lu2_fwd0", 0);
        expect_val("lu2_inflight", 3'b010);
        expect_val("lu2_stall_cnt", 1);
        settle();
        check({stall_fd, bubble_da});
        check(fwd_sel[3:2]);
        check(fwd_sel[1:0]);
        check(inflight);
        check(stall_cnt);
        next_cycle();

        // x0 destination and unused ports
        do_reset();
        set_d(1, 5'd0, 1, 0, 5'd0, 5'd0, 2'b00);
        next_cycle();
        set_d(1, 5'd9, 1, 1, 5'd0, 5'd0, 2'b11);
        expect_val("x0_fwd", 0);
        expect_val("x0_stall", 0);
        settle();
        check(fwd_sel);
        check(stall_fd);
        next_cycle();
        set_d(1, 5'd10, 1, 0, 5'd9, 5'd9, 2'b00);
        expect_val("unused_fwd", 0);
        expect_val("unused_stall", 0);
        expect_val("unused_stall_cnt", 0);
        settle();
        check(fwd_sel);
        check(stall_fd);
        check(stall_cnt);
        next_cycle();

        // Memory wait: three cycles with mem_ready low, then ready
        do_reset();
        set_d(1, 5'd3, 1, 1, 5'd0, 5'd0, 2'b00);
        next_cycle();
        set_d(1, 5'd4, 1, 0, 5'd0, 5'd0, 2'b00);
        next_cycle();
        set_d(1, 5'd11, 1, 0, 5'd0, 5'd0, 2'b00);
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_val($sformatf("mw%0d_hold_stall_bubble_flush", i), 4'b1100);
            expect_val($sformatf("mw%0d_inflight", i), 3'b011);
            expect_val($sformatf("mw%0d_stall_cnt", i), i);
            settle();
            check({hold_pipe, stall_fd, bubble_da, flush_fd});
            check(inflight);
            check(stall_cnt);
            next_cycle();
        end
        mem_ready = 1'b1;
        expect_val("mw_ready_hold_stall", 2'b00);
        expect_val("mw_ready_stall_cnt", 3);
        expect_val("mw_ready_inflight", 3'b011);
        settle();
        check({hold_pipe, stall_fd});
        check(stall_cnt);
        check(inflight);
        next_cycle();
        idle();
        expect_val("mw_advance_inflight", 3'b111);
        expect_val("mw_after_stall_cnt", 3);
        settle();
        check(inflight);
        check(stall_cnt);
        next_cycle();

        // Branch during a load-use stall
        do_reset();
        set_d(1, 5'd7, 1, 1, 5'd0, 5'd0, 2'b00);
        next_cycle();
        set_d(1, 5'd0, 0, 0, 5'd7, 5'd0, 2'b01);
        br_en = 1'b1;
        expect_val("br_stall", 1);
        expect_val("br_flush_stalled", 0);
        settle();
        check(stall_fd);
        check(flush_fd);
        next_cycle();
        expect_val("br_flush_next", 1);
        expect_val("br_stall_next", 0);
        settle();
        check(flush_fd);
        check(stall_fd);
        next_cycle();
        idle();
        expect_val("br_flush_cnt", 1);
        expect_val("br_stall_cnt", 1);
        expect_val("br_flush_idle", 0);
        settle();
        check(flush_cnt);
        check(stall_cnt);
        check(flush_fd);
        next_cycle();

        // Reset asserted during a memory wait
        do_reset();
        set_d(1, 5'd3, 1, 1, 5'd0, 5'd0, 2'b00);
        next_cycle();
        set_d(1, 5'd4, 1, 0, 5'd0, 5'd0, 2'b00);
        next_cycle();
        set_d(1, 5'd12, 1, 0, 5'd3, 5'd4, 2'b11);
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        expect_val("rw_hold", 1);
        settle();
        check(hold_pipe);
        next_cycle();
        expect_val("rw_stall_cnt_pre", 1);
        settle();
        check(stall_cnt);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        expect_val("rw_inflight", 0);
        expect_val("rw_stall_cnt", 0);
        expect_val("rw_flush_cnt", 0);
        expect_val("rw_ctrl", 0);
        expect_val("rw_fwd", 0);
        settle();
        check(inflight);
        check(stall_cnt);
        check(flush_cnt);
        check({stall_fd, bubble_da, hold_pipe, flush_fd});
        check(fwd_sel);
        next_cycle();
        idle();

        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_leftover: got %0d pending, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
